pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register: the generic successor to the fixed-width EX/MEM latch. It carries a DATA_W-bit payload and a CTRL_W-bit control bundle between two pipeline stages under a valid/ready handshake. It supports stall (back-pressure), flush (bubble injection) and an optional skid buffer that gives a registered in_ready. It sits between any two stages of the MIPS pipeline (IF/ID, ID/EX, EX/ME, ME/WB) and replaces the per-stage hand-built registers.

## Interface
- DATA_W, 101: payload width (operands, destination register, ALU result).
- CTRL_W, 6: control bundle width (Mem2Reg, RegWr, MemWr, branch[1:0], alures). Forced to zero whenever the stage holds a bubble.
- STALL_CNT_W, 16: width of the saturating stall counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_data/in_ctrl.
- in_ready  out  1  stage accepts this cycle; a transfer happens when in_valid && in_ready.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control bundle.
- flush  in  1  discard all held and incoming entries (branch taken / hazard squash).
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream consumes; a transfer happens when out_valid && out_ready.
- out_data  out  DATA_W  held payload.
- out_ctrl  out  CTRL_W  held control; all zeros when out_valid=0.
- stall_cnt  out  STALL_CNT_W  count of cycles with out_valid && !out_ready; saturates at all-ones.

## Operation
- Main register M holds {valid, data, ctrl}. out_* are driven directly from M; no combinational path from in_* to out_*.
- Accept: on an input transfer with M empty, or with M being consumed in the same cycle, M loads the input.
- Hold: while out_valid && !out_ready, out_data and out_ctrl remain bit-stable.
- Consume without a new input: M.valid clears. M.ctrl clears to 0. M.data is don't-care but must not be X after reset.
- Flush has priority over every other event in the same cycle:
  - Next cycle, M and the skid register (S) are invalid and their ctrl is zero.
  - Any input presented in the flush cycle is dropped, even if in_ready was 1.
  - stall_cnt is unaffected.
- out_ctrl = M.valid ? M.ctrl : 0, so a bubble always presents as a NOP to downstream.
- stall_cnt increments by 1 in each cycle where out_valid && !out_ready, stopping at 2^STALL_CNT_W-1. Only rst clears it.
- Reset, at the clock edge with rst=1:
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - S empty.
  - in_ready=0 while rst is high and 1 in the first cycle after rst drops.
- Reset asserted mid-transfer discards all entries. Partial state is never visible afterwards.

## Timing
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 entry per cycle with out_ready held high.
- Without skid: in_ready = !rst && (!out_valid || out_ready). This is a combinational path from out_ready. Capacity is 1.
- With skid: in_ready is a flop, 1 iff S is empty. Capacity is 2.
  - If an input arrives while M is full and not consumed, it goes to S.
  - When M is consumed, S moves to M in the next cycle, and a simultaneous input lands in S if S is being vacated.
  - Ordering is strictly FIFO; an entry never overtakes another.
- Simultaneous input transfer and output transfer with M full and S empty: M takes the input and S stays empty.
- Flush takes effect one cycle after assertion. out_valid=0 in the cycle after flush regardless of in_valid. in_ready behaves normally in the flush cycle.

## Configuration
- PIPE_STAGE_SKID_EN defined: skid register S compiled in.
  - in_ready is registered with no out_ready→in_ready combinational path.
  - Capacity is 2 and full throughput is kept under back-pressure.
- PIPE_STAGE_SKID_EN undefined: S absent.
  - in_ready is combinational as above and capacity is 1.
  - Port list and all other behaviour are identical.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0x1234 → out_valid=0, out_ctrl=0, stall_cnt=0, and in_ready=0 during rst. First cycle after rst: in_ready=1.
- Streaming: 8 inputs in back-to-back cycles, data 1..8 and ctrl 6'h3F, with out_ready=1 → out_valid from cycle 1, out_data 1..8 in order with no gaps, stall_cnt=0.
- Back-pressure: out_ready=0 for 5 cycles while in_valid=1 with data A,B,C,…
  - out_data stays A throughout.
  - Skid build: B is held in S and in_ready=0 from the second cycle. Non-skid build: in_ready=0 as soon as A is held.
  - stall_cnt=5. Releasing out_ready delivers A then B with no loss or duplication.
- Flush: M (and S) full, flush=1 for one cycle with in_valid=1 and data=0xDEAD → next cycle out_valid=0 and out_ctrl=0. 0xDEAD never appears on the output. The entry presented in the following cycle emerges normally.
- Saturation: STALL_CNT_W=3, out_ready=0 for 12 cycles with the stage full → stall_cnt reads 7 and holds at 7.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry, which registers in_ready and doubles capacity.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 101,
  parameter int unsigned CTRL_W      = 6,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   m_valid_q, m_valid_d;
  logic [DATA_W-1:0]      m_data_q, m_data_d;
  logic [CTRL_W-1:0]      m_ctrl_q, m_ctrl_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   in_xfer;
  logic                   out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = m_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  // Ready depends only on the skid flop, so out_ready never reaches in_ready.
  assign in_ready = !rst && !s_valid_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (!m_valid_q || out_xfer) begin
      if (s_valid_q) begin
        // Oldest entry advances from S; a new input refills the vacated S.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = in_xfer;
        s_data_d  = in_xfer ? in_data : s_data_q;
        s_ctrl_d  = in_xfer ? in_ctrl : '0;
      end else if (in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (in_xfer) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end
`else
  assign in_ready = !rst && (!m_valid_q || out_ready);

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (in_xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = in_data;
      m_ctrl_d  = in_ctrl;
    end else if (out_xfer) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_ctrl_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_ctrl_q    <= m_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table for reset/streaming, hand sequences for back-pressure,
// flush, mid-transfer reset and counter saturation, with a FIFO scoreboard on every transfer.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 101;
  localparam int unsigned CW = 6;
  localparam int unsigned SW = 16;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b1;
  logic          in_ready;
  logic [DW-1:0] in_data = DW'(16'h1234);
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [SW-1:0] stall_cnt;

  logic          sat_in_ready;
  logic          sat_out_valid;
  logic [DW-1:0] sat_out_data;
  logic [CW-1:0] sat_out_ctrl;
  logic [2:0]    sat_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_data(sat_out_data), .out_ctrl(sat_out_ctrl), .stall_cnt(sat_stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+CW-1:0] sb_q[$];
  logic [DW+CW-1:0] sb_exp;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic fl, input logic ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Scoreboard: accepted inputs queue up, every output transfer must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got data 0x%0h, want no output", out_data);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("sb_order", 128'({out_data, out_ctrl}), 128'(sb_exp));
        end
      end
      if (!out_valid) chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({in_data, in_ctrl});
    end
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic [5:0]  c;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic        chk_d;
    logic [15:0] e_d;
    logic [5:0]  e_c;
    logic [15:0] e_st;
  } vec_t;

  vec_t tv[12];
  logic bp_ir;
  int   idx;

  initial begin
    // Reset for two cycles with a valid input offered, then stream 1..8.
    tv[0] = '{1'b1, 1'b1, 16'h1234, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 6'h00, 16'h0};
    tv[1] = '{1'b0, 1'b0, 16'h0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0, 6'h00, 16'h0};
    for (int i = 2; i < 10; i++) begin
      tv[i] = '{1'b0, 1'b1, 16'(i - 1), 6'h3F, 1'b1, 1'b1, (i >= 3), (i >= 3), 16'(i - 2),
                (i >= 3) ? 6'h3F : 6'h00, 16'h0};
    end
    tv[10] = '{1'b0, 1'b0, 16'h0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'd8, 6'h3F, 16'h0};
    tv[11] = '{1'b0, 1'b0, 16'h0, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 6'h00, 16'h0};

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].rst, tv[i].iv, DW'(tv[i].d), tv[i].c, 1'b0, tv[i].ordy);
      chk($sformatf("tv%0d_in_ready", i), 128'(in_ready), 128'(tv[i].e_ir));
      chk($sformatf("tv%0d_out_valid", i), 128'(out_valid), 128'(tv[i].e_ov));
      chk($sformatf("tv%0d_out_ctrl", i), 128'(out_ctrl), 128'(tv[i].e_c));
      if (tv[i].chk_d) chk($sformatf("tv%0d_out_data", i), 128'(out_data), 128'(tv[i].e_d));
      chk($sformatf("tv%0d_stall", i), 128'(stall_cnt), 128'(tv[i].e_st));
    end

    // Back-pressure: A held for 5 stalled cycles, then A and B delivered in order.
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1'b0, cyc < 7, DW'(16'hA0 + idx), 6'h15, 1'b0, cyc >= 6);
      if (cyc == 0)      bp_ir = 1'b1;
      else if (cyc == 1) bp_ir = SKID;
      else if (cyc == 6) bp_ir = !SKID;
      else               bp_ir = 1'b0;
      if (cyc < 7) chk($sformatf("bp%0d_in_ready", cyc), 128'(in_ready), 128'(bp_ir));
      if (cyc >= 1 && cyc <= 6) begin
        chk($sformatf("bp%0d_out_valid", cyc), 128'(out_valid), 128'(1));
        chk($sformatf("bp%0d_out_data", cyc), 128'(out_data), 128'(16'hA0));
      end
      if (cyc == 6) chk("bp_stall_cnt", 128'(stall_cnt), 128'(5));
      if (cyc == 7) chk("bp_second_out", 128'(out_data), 128'(16'hA1));
      if (in_valid && in_ready) idx++;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("bp_drained", 128'(out_valid), 128'(0));

    // Flush: stage full, flush under stall, then flush with in_ready=1; DEAD must never appear.
    drive(1'b0, 1'b1, DW'(16'h51), 6'h2A, 1'b0, 1'b0);
    chk("fl_in_ready0", 128'(in_ready), 128'(1));
    drive(1'b0, 1'b1, DW'(16'h52), 6'h2A, 1'b0, 1'b0);
    chk("fl_in_ready1", 128'(in_ready), 128'(SKID));
    chk("fl_held", 128'(out_data), 128'(16'h51));
    drive(1'b0, 1'b1, DW'(16'hDEAD), 6'h3F, 1'b1, 1'b0);
    chk("fl_in_ready2", 128'(in_ready), 128'(0));
    chk("fl_stall_pre", 128'(stall_cnt), 128'(6));
    drive(1'b0, 1'b1, DW'(16'hDEAD), 6'h3F, 1'b1, 1'b1);
    chk("fl_out_valid", 128'(out_valid), 128'(0));
    chk("fl_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("fl_stall_kept", 128'(stall_cnt), 128'(7));
    chk("fl_in_ready3", 128'(in_ready), 128'(1));
    drive(1'b0, 1'b1, DW'(16'h77), 6'h0C, 1'b0, 1'b1);
    chk("fl_dropped", 128'(out_valid), 128'(0));
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("fl_next_valid", 128'(out_valid), 128'(1));
    chk("fl_next_data", 128'(out_data), 128'(16'h77));
    chk("fl_next_ctrl", 128'(out_ctrl), 128'(6'h0C));
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("fl_empty", 128'(out_valid), 128'(0));

    // Reset with an entry held discards it.
    drive(1'b0, 1'b1, DW'(16'hBEEF), 6'h01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, DW'(16'h1111), 6'h01, 1'b0, 1'b0);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_stall", 128'(stall_cnt), 128'(0));
    chk("rst_in_ready_after", 128'(in_ready), 128'(1));

    // Saturation: 3-bit counter stops at 7, 16-bit counter keeps counting.
    drive(1'b0, 1'b1, DW'(16'h5A5A), 6'h33, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (k == 7) chk("sat_6", 128'(sat_stall_cnt), 128'(6));
      if (k == 8 || k == 13) begin
        chk($sformatf("sat_%0d", k), 128'(sat_stall_cnt), 128'(7));
        chk($sformatf("wide_%0d", k), 128'(stall_cnt), 128'(k - 1));
        chk($sformatf("sat_hold_data_%0d", k), 128'(out_data), 128'(16'h5A5A));
      end
    end
    chk("sat_out_valid", 128'(sat_out_valid), 128'(1));
    chk("sat_out_data", 128'(sat_out_data), 128'(16'h5A5A));
    chk("sat_out_ctrl", 128'(sat_out_ctrl), 128'(6'h33));
    chk("sat_in_ready", 128'(sat_in_ready), 128'(SKID));
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("end_empty", 128'(out_valid), 128'(0));
    chk("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
